// File: rtl/key_switch_detect.sv
// key_switch_detect: debounces the two board keys into the emulated wall-switch level.
// Define SWITCH_FLICK_EN to compile in the Key[1] flick (timed off-then-on) behaviour.
module key_switch_detect #(
  parameter int TICK_DIV       = 5000,
  parameter int DEBOUNCE_TICKS = 200,
  parameter int FLICK_TICKS    = 3000
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic [1:0] Key,
  output logic       fake_switch,
  output logic [1:0] Key_Press,
  output logic       flick_busy
);
  if (TICK_DIV < 2 || TICK_DIV > 8191) begin : g_bad_div
    $error("TICK_DIV out of range 2..8191");
  end
  if (DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 65535) begin : g_bad_db
    $error("DEBOUNCE_TICKS out of range 1..65535");
  end
  if (FLICK_TICKS < 1 || FLICK_TICKS > 65535) begin : g_bad_flick
    $error("FLICK_TICKS out of range 1..65535");
  end
  localparam logic [12:0] DIV_MAX = 13'(TICK_DIV - 1);
  localparam logic [15:0] DB_MAX  = 16'(DEBOUNCE_TICKS - 1);
  typedef enum logic [1:0] {
    OFF = 2'd0,
    ON  = 2'd1
`ifdef SWITCH_FLICK_EN
    , FLICK = 2'd2
`endif
  } state_t;
  logic [1:0]       sync0, sync1, stable, stable_d;
  logic [12:0]      div_cnt;
  logic [1:0][15:0] db_cnt;
  logic             tick;
  state_t           state, state_next;
  assign tick = div_cnt == DIV_MAX;
  always_ff @(posedge Sys_CLK)
    if (Sys_RST) begin
      sync0   <= 2'b11;
      sync1   <= 2'b11;
      div_cnt <= '0;
    end else begin
      sync0   <= Key;
      sync1   <= sync0;
      div_cnt <= tick ? '0 : div_cnt + 13'd1;
    end
  // counter only runs while the synced level disagrees with the accepted level
  always_ff @(posedge Sys_CLK)
    if (Sys_RST) begin
      db_cnt    <= '0;
      stable    <= 2'b11;
      stable_d  <= 2'b11;
      Key_Press <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++)
        if (sync1[k] == stable[k]) db_cnt[k] <= '0;
        else if (tick) begin
          db_cnt[k] <= db_cnt[k] == DB_MAX ? '0 : db_cnt[k] + 16'd1;
          if (db_cnt[k] == DB_MAX) stable[k] <= sync1[k];
        end
      stable_d  <= stable;
      Key_Press <= stable_d & ~stable;
    end
`ifdef SWITCH_FLICK_EN
  localparam logic [15:0] FL_LOAD = 16'(FLICK_TICKS);
  logic [15:0] timer;
  logic        expire;
  assign expire = tick && timer <= 16'd1;
  always_comb begin
    state_next = state;
    case (state)
      OFF:     state_next = Key_Press[0] ? ON : OFF;
      ON:      state_next = Key_Press[0] ? OFF : Key_Press[1] ? FLICK : ON;
      FLICK:   state_next = Key_Press[0] ? OFF : Key_Press[1] ? FLICK : expire ? ON : FLICK;
      default: state_next = OFF;
    endcase
  end
  // a Key[1] press while already flicking restarts the off period
  always_ff @(posedge Sys_CLK)
    if (Sys_RST || state_next != FLICK) timer <= '0;
    else if (state != FLICK || Key_Press[1]) timer <= FL_LOAD;
    else if (tick) timer <= timer - 16'd1;
  always_ff @(posedge Sys_CLK)
    if (Sys_RST) begin
      state       <= OFF;
      fake_switch <= 1'b0;
      flick_busy  <= 1'b0;
    end else begin
      state       <= state_next;
      fake_switch <= state_next == ON;
      flick_busy  <= state_next == FLICK;
    end
`else
  always_comb begin
    state_next = state;
    case (state)
      OFF:     state_next = Key_Press[0] ? ON : OFF;
      ON:      state_next = Key_Press[0] ? OFF : ON;
      default: state_next = OFF;
    endcase
  end
  always_ff @(posedge Sys_CLK)
    if (Sys_RST) begin
      state       <= OFF;
      fake_switch <= 1'b0;
    end else begin
      state       <= state_next;
      fake_switch <= state_next == ON;
    end
  assign flick_busy = 1'b0;
`endif
endmodule
